// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter granting synchronized, edge-detected async request lines to one engine.
// Optional SERVE watchdog enabled by defining SYNC_ARB_TIMEOUT_EN (adds timeout_err port).
module sync_req_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned DFF     = 2,
  parameter int unsigned FILTER  = 2,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned IDW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_async,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  input  logic           gnt_ready,
  input  logic           done,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [N-1:0]   pending
`ifdef SYNC_ARB_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);

  typedef enum logic [1:0] {StIdle, StOffer, StServe} state_e;

  state_e         state_q;
  logic [DFF-1:0] sync_q [N];
  logic [N-1:0]   lvl;
  logic [N-1:0]   lvl_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   clr;
  logic [N-1:0]   gnt_onehot;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] pick_id;
  logic           timeout_hit;

  // Bit 0 is the first stage; bit DFF-1 is the last stage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (!rst) begin
        sync_q[i] <= '0;
      end else begin
        sync_q[i] <= {sync_q[i][DFF-2:0], req_async[i]};
      end
    end
  end

  always_comb begin
    lvl = '0;
    for (int i = 0; i < int'(N); i++) begin
      case (FILTER)
        0:       lvl[i] = |sync_q[i];
        1:       lvl[i] = &sync_q[i];
        default: lvl[i] = sync_q[i][DFF-1];
      endcase
    end
  end

  assign rise = lvl & ~lvl_q;

  always_comb begin
    gnt_onehot         = '0;
    gnt_onehot[gnt_id] = 1'b1;
  end

  always_comb begin
    clr = '0;
    if (state_q == StServe && (done || timeout_hit)) begin
      clr = gnt_onehot;
    end
  end

  // A rising edge in the same cycle as a clear keeps the line pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q     <= '0;
      pending_q <= '0;
    end else begin
      lvl_q     <= lvl;
      pending_q <= (pending_q & ~clr) | rise;
    end
  end

  assign pending = pending_q;

  // Walk downward so the candidate closest to ptr (k = 0) is written last and wins.
  always_comb begin
    logic [IDW-1:0] idx;
    pick_id = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr_q) + k) % int'(N));
      if (pending_q[idx]) begin
        pick_id = idx;
      end
    end
  end

  assign ptr_nxt = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // cnt_q holds the index of the current SERVE cycle, starting at 1.
  assign timeout_hit = (state_q == StServe) && !done && (cnt_q == CW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_valid   <= 1'b0;
      gnt_id      <= '0;
      ack         <= '0;
      busy        <= 1'b0;
`ifdef SYNC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef SYNC_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|pending_q) begin
            gnt_id    <= pick_id;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StOffer;
          end
        end
        StOffer: begin
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            state_q   <= StServe;
`ifdef SYNC_ARB_TIMEOUT_EN
            cnt_q     <= CW'(1);
`endif
          end
        end
        StServe: begin
          if (done) begin
            ack     <= gnt_onehot;
            busy    <= 1'b0;
            ptr_q   <= ptr_nxt;
            state_q <= StIdle;
          end
`ifdef SYNC_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            ptr_q       <= ptr_nxt;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Self-checking bench for sync_req_arbiter: directed scenarios plus a randomized run
// against a queue-based behavioural model.
module tb_sync_req_arbiter;
  localparam int N = 4;
  localparam int ADFF = 2;
  localparam int ATIMEOUT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_a;
  logic [3:0] req_f;
  logic       gnt_ready;
  logic       done;
  logic       idle_ready;
  logic       idle_done;

  logic       a_gnt_valid, b_gnt_valid, c_gnt_valid;
  logic [1:0] a_gnt_id, b_gnt_id, c_gnt_id;
  logic [3:0] a_ack, b_ack, c_ack;
  logic       a_busy, b_busy, c_busy;
  logic [3:0] a_pending, b_pending, c_pending;
`ifdef SYNC_ARB_TIMEOUT_EN
  logic       a_terr, b_terr, c_terr;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] m_samp[$];
  logic [3:0] m_lvld;
  logic [3:0] m_pend;
  logic [3:0] m_ack;
  int         m_phase;  // 0 idle, 1 offer, 2 serve
  int         m_id;
  int         m_ptr;
  int         m_cnt;
  bit         m_terr;

  always #5 clk = ~clk;

  sync_req_arbiter #(.N(4), .DFF(2), .FILTER(2), .TIMEOUT(ATIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_async(req_a), .gnt_valid(a_gnt_valid), .gnt_id(a_gnt_id),
    .gnt_ready(gnt_ready), .done(done), .ack(a_ack), .busy(a_busy), .pending(a_pending)
`ifdef SYNC_ARB_TIMEOUT_EN
    , .timeout_err(a_terr)
`endif
  );

  sync_req_arbiter #(.N(4), .DFF(3), .FILTER(1), .TIMEOUT(ATIMEOUT)) dut_and (
    .clk(clk), .rst(rst), .req_async(req_f), .gnt_valid(b_gnt_valid), .gnt_id(b_gnt_id),
    .gnt_ready(idle_ready), .done(idle_done), .ack(b_ack), .busy(b_busy), .pending(b_pending)
`ifdef SYNC_ARB_TIMEOUT_EN
    , .timeout_err(b_terr)
`endif
  );

  sync_req_arbiter #(.N(4), .DFF(3), .FILTER(0), .TIMEOUT(ATIMEOUT)) dut_or (
    .clk(clk), .rst(rst), .req_async(req_f), .gnt_valid(c_gnt_valid), .gnt_id(c_gnt_id),
    .gnt_ready(idle_ready), .done(idle_done), .ack(c_ack), .busy(c_busy), .pending(c_pending)
`ifdef SYNC_ARB_TIMEOUT_EN
    , .timeout_err(c_terr)
`endif
  );

  // Advance the model by one clock edge from the inputs present at that edge.
  task automatic model_update();
    logic [3:0] lvl, rise, clr;
    if (!rst) begin
      m_samp = {};
      for (int i = 0; i < ADFF; i++) m_samp.push_back(4'b0);
      m_lvld = '0; m_pend = '0; m_ack = '0;
      m_phase = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_terr = 0;
      return;
    end
    lvl = m_samp[0];  // oldest sample is the last synchronizer stage
    m_samp.push_back(req_a);
    void'(m_samp.pop_front());
    rise = lvl & ~m_lvld;
    m_lvld = lvl;
    clr = '0; m_ack = '0; m_terr = 0;
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_pend[(m_ptr + k) % N]) begin
            m_id = (m_ptr + k) % N;
            break;
          end
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (gnt_ready) begin m_phase = 2; m_cnt = 1; end
    end else begin
      if (done) begin
        clr[m_id] = 1'b1; m_ack[m_id] = 1'b1;
        m_ptr = (m_id + 1) % N; m_phase = 0;
      end
`ifdef SYNC_ARB_TIMEOUT_EN
      else if (m_cnt == ATIMEOUT) begin
        clr[m_id] = 1'b1; m_terr = 1;
        m_ptr = (m_id + 1) % N; m_phase = 0;
      end else begin
        m_cnt++;
      end
`endif
    end
    m_pend = (m_pend & ~clr) | rise;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = (a_gnt_valid === 1'b1);
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (a_gnt_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({a_gnt_valid, a_gnt_id, a_ack, a_busy, a_pending} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b id=%0d ack=%b busy=%b pend=%b required all 0",
               a_gnt_valid, a_gnt_id, a_ack, a_busy, a_pending);
    end
    n_checks++;
    if ({b_pending, c_pending, b_busy, c_busy} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_filter_dut: got b_pend=%b c_pend=%b required 0", b_pending, c_pending);
    end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    req_a = 4'b0100;
    tick(); tick();
    n_checks++;
    if (a_pending !== 4'b0000) begin
      n_fail++; $display("FAIL latency_early: pending=%b required 0000", a_pending);
    end
    tick();
    n_checks++;
    if (a_pending !== 4'b0100 || a_gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pending: pending=%b valid=%b required 0100/0", a_pending, a_gnt_valid);
    end
    tick();
    n_checks++;
    if (a_gnt_valid !== 1'b1 || a_gnt_id !== 2'd2 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_grant: valid=%b id=%0d busy=%b required 1/2/1",
               a_gnt_valid, a_gnt_id, a_busy);
    end
  endtask

  task automatic test_handshake();
    int bad = 0;
    gnt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_gnt_valid !== 1'b1 || a_gnt_id !== 2'd2) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL offer_hold: %0d unstable cycles, required 0", bad);
    end
    gnt_ready = 1'b1;
    tick();
    gnt_ready = 1'b0;
    n_checks++;
    if (a_gnt_valid !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL accept: valid=%b busy=%b required 0/1", a_gnt_valid, a_busy);
    end
    bad = 0;
    repeat (3) begin
      tick();
      if (a_ack !== 4'b0 || a_busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL serve_wait: %0d bad cycles, required 0", bad);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (a_ack !== 4'b0100 || a_busy !== 1'b0 || a_pending !== 4'b0) begin
      n_fail++;
      $display("FAIL done_ack: ack=%b busy=%b pend=%b required 0100/0/0000",
               a_ack, a_busy, a_pending);
    end
    tick();
    n_checks++;
    if (a_ack !== 4'b0 || a_gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_pulse: ack=%b valid=%b required 0000/0", a_ack, a_gnt_valid);
    end
  endtask

  task automatic test_rr_wrap();
    int exp_ids[3] = '{3, 0, 1};
    bit ok;
    req_a = 4'b1011;
    repeat (3) tick();
    n_checks++;
    if (a_pending !== 4'b1011) begin
      n_fail++; $display("FAIL rr_pending: pending=%b required 1011", a_pending);
    end
    for (int g = 0; g < 4; g++) begin
      int e;
      if (g == 3) begin
        req_a = 4'b0011;
        repeat (3) tick();
        req_a = 4'b1011;
        e = 3;
      end else begin
        e = exp_ids[g];
      end
      wait_valid(ok);
      n_checks++;
      if (!ok || a_gnt_id !== 2'(e)) begin
        n_fail++; $display("FAIL rr_grant%0d: valid=%b id=%0d required 1/%0d", g, ok, a_gnt_id, e);
      end
      gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
      done = 1'b1; tick(); done = 1'b0;
      n_checks++;
      if (a_ack !== 4'(1 << e)) begin
        n_fail++; $display("FAIL rr_ack%0d: ack=%b required %b", g, a_ack, 4'(1 << e));
      end
    end
  endtask

  task automatic test_set_wins();
    bit ok;
    req_a = 4'b0000;
    repeat (3) tick();
    req_a = 4'b0010;
    wait_valid(ok);
    n_checks++;
    if (!ok || a_gnt_id !== 2'd1) begin
      n_fail++; $display("FAIL sw_grant: valid=%b id=%0d required 1/1", ok, a_gnt_id);
    end
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    req_a = 4'b0000;
    repeat (3) tick();
    req_a = 4'b0010;
    tick(); tick();
    done = 1'b1; tick(); done = 1'b0;
    n_checks++;
    if (a_ack !== 4'b0010 || a_pending[1] !== 1'b1) begin
      n_fail++; $display("FAIL set_wins: ack=%b pend=%b required 0010/x1x", a_ack, a_pending);
    end
    wait_valid(ok);
    n_checks++;
    if (!ok || a_gnt_id !== 2'd1) begin
      n_fail++; $display("FAIL sw_regrant: valid=%b id=%0d required 1/1", ok, a_gnt_id);
    end
    gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    n_checks++;
    if (a_ack !== 4'b0010 || a_pending !== 4'b0) begin
      n_fail++; $display("FAIL sw_reack: ack=%b pend=%b required 0010/0000", a_ack, a_pending);
    end
  endtask

  task automatic test_filter();
    int bad = 0;
    req_f = 4'b0001;
    tick();
    n_checks++;
    if (c_pending !== 4'b0) begin
      n_fail++; $display("FAIL or_early: pend=%b required 0000", c_pending);
    end
    tick();
    req_f = 4'b0000;
    n_checks++;
    if (c_pending !== 4'b0001) begin
      n_fail++; $display("FAIL or_glitch: pend=%b required 0001", c_pending);
    end
    repeat (5) begin
      tick();
      if (b_pending !== 4'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL and_glitch: %0d cycles pending set, required 0", bad);
    end
    req_f = 4'b0001;
    repeat (3) tick();
    n_checks++;
    if (b_pending !== 4'b0) begin
      n_fail++; $display("FAIL and_early: pend=%b required 0000", b_pending);
    end
    tick();
    req_f = 4'b0000;
    n_checks++;
    if (b_pending !== 4'b0001) begin
      n_fail++; $display("FAIL and_level: pend=%b required 0001", b_pending);
    end
  endtask

`ifdef SYNC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      req_a = 4'b0000;
      repeat (3) tick();
      req_a = 4'b0001;
      wait_valid(ok);
      n_checks++;
      if (!ok || a_gnt_id !== 2'd0) begin
        n_fail++; $display("FAIL to_grant%0d: valid=%b id=%0d required 1/0", pass, ok, a_gnt_id);
      end
      gnt_ready = 1'b1; tick(); gnt_ready = 1'b0;
      bad = 0;
      repeat (ATIMEOUT - 1) begin
        tick();
        if (a_terr !== 1'b0 || a_busy !== 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL to_early%0d: %0d bad cycles, required 0", pass, bad);
      end
      done = (pass == 1);
      tick();
      done = 1'b0;
      n_checks++;
      if (pass == 0 && (a_terr !== 1'b1 || a_ack !== 4'b0 || a_busy !== 1'b0 ||
                        a_pending !== 4'b0)) begin
        n_fail++;
        $display("FAIL to_fire: terr=%b ack=%b busy=%b pend=%b required 1/0000/0/0000",
                 a_terr, a_ack, a_busy, a_pending);
      end else if (pass == 1 && (a_terr !== 1'b0 || a_ack !== 4'b0001)) begin
        n_fail++; $display("FAIL to_done_wins: terr=%b ack=%b required 0/0001", a_terr, a_ack);
      end
      tick();
      n_checks++;
      if (a_terr !== 1'b0) begin
        n_fail++; $display("FAIL to_pulse%0d: terr=%b required 0", pass, a_terr);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit bad;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req_a[i] = ~req_a[i];
      end
      gnt_ready = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) != 0);
      tick();
      bad = (a_gnt_valid !== (m_phase == 1)) || (a_busy !== (m_phase != 0)) ||
            (a_gnt_id !== 2'(m_id)) || (a_ack !== m_ack) || (a_pending !== m_pend);
`ifdef SYNC_ARB_TIMEOUT_EN
      bad = bad || (a_terr !== m_terr);
`endif
      n_checks++;
      if (bad) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random_cycle%0d: got v=%b id=%0d ack=%b busy=%b pend=%b required v=%b id=%0d ack=%b busy=%b pend=%b",
                   cyc, a_gnt_valid, a_gnt_id, a_ack, a_busy, a_pending,
                   m_phase == 1, m_id, m_ack, m_phase != 0, m_pend);
      end
    end
    rst = 1'b1; done = 1'b0; gnt_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_a = '0; req_f = '0;
    gnt_ready = 1'b0; done = 1'b0;
    idle_ready = 1'b0; idle_done = 1'b0;
    test_reset();
    test_latency();
    test_handshake();
    test_rr_wrap();
    test_set_wins();
    test_filter();
`ifdef SYNC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
